// File: rtl/calc1_port_driver.sv
// Request sequencer for one calc1 port: queues host (cmd, op1, op2) operations,
// drives the two-cycle calc1 request, waits for out_resp and hands code/data back to the host.
module calc1_port_driver #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   c_clk,
    input  logic                   reset,
    input  logic                   host_req_valid,
    output logic                   host_req_ready,
    input  logic [0:3]             host_req_cmd,
    input  logic [0:31]            host_req_op1,
    input  logic [0:31]            host_req_op2,
    output logic                   host_rsp_valid,
    input  logic                   host_rsp_ready,
    output logic [0:1]             host_rsp_code,
    output logic [0:31]            host_rsp_data,
    output logic [0:3]             req_cmd_in,
    output logic [0:31]            req_data_in,
    input  logic [0:1]             out_resp,
    input  logic [0:31]            out_data,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   spurious_resp
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND_OP1,
        SEND_OP2,
        WAIT_RESP,
        HOLD
    } state_t;

    state_t state, state_nx;

    logic [0:3]  cmd_mem [DEPTH];
    logic [0:31] op1_mem [DEPTH];
    logic [0:31] op2_mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop;

    logic [0:31]   op2_q, op2_nx;
    logic [TW-1:0] wait_cnt, wait_nx;
    logic [0:3]    cmd_nx;
    logic [0:31]   bus_data_nx;
    logic          valid_nx;
    logic [0:1]    code_nx;
    logic [0:31]   rsp_data_nx;
    logic          spur_nx;

    // Ready looks only at the registered count, so a full FIFO refuses even while popping.
    assign host_req_ready = (count < FULL);
    assign push           = host_req_valid && host_req_ready;
    assign fifo_count     = count;

    always_ff @(posedge c_clk) begin
        if (push) begin
            cmd_mem[wr_ptr] <= host_req_cmd;
            op1_mem[wr_ptr] <= host_req_op1;
            op2_mem[wr_ptr] <= host_req_op2;
        end
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            state          <= IDLE;
            op2_q          <= '0;
            wait_cnt       <= '0;
            req_cmd_in     <= '0;
            req_data_in    <= '0;
            host_rsp_valid <= 1'b0;
            host_rsp_code  <= '0;
            host_rsp_data  <= '0;
            spurious_resp  <= 1'b0;
        end else begin
            state          <= state_nx;
            op2_q          <= op2_nx;
            wait_cnt       <= wait_nx;
            req_cmd_in     <= cmd_nx;
            req_data_in    <= bus_data_nx;
            host_rsp_valid <= valid_nx;
            host_rsp_code  <= code_nx;
            host_rsp_data  <= rsp_data_nx;
            spurious_resp  <= spur_nx;
        end
    end

    // Outputs are computed for the state being entered, so the bus and response lines are registered.
    always_comb begin
        state_nx    = state;
        pop         = 1'b0;
        op2_nx      = op2_q;
        wait_nx     = wait_cnt;
        cmd_nx      = '0;
        bus_data_nx = '0;
        valid_nx    = host_rsp_valid;
        code_nx     = host_rsp_code;
        rsp_data_nx = host_rsp_data;
        spur_nx     = (state != WAIT_RESP) && (out_resp != 2'd0);

        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop         = 1'b1;
                    op2_nx      = op2_mem[rd_ptr];
                    cmd_nx      = cmd_mem[rd_ptr];
                    bus_data_nx = op1_mem[rd_ptr];
                    state_nx    = SEND_OP1;
                end
            end
            SEND_OP1: begin
                bus_data_nx = op2_q;
                state_nx    = SEND_OP2;
            end
            SEND_OP2: begin
                wait_nx  = '0;
                state_nx = WAIT_RESP;
            end
            WAIT_RESP: begin
                if (out_resp != 2'd0) begin
                    valid_nx    = 1'b1;
                    code_nx     = out_resp;
                    rsp_data_nx = out_data;
                    state_nx    = HOLD;
                end else if (wait_cnt == WAIT_LAST) begin
                    valid_nx    = 1'b1;
                    code_nx     = 2'd3;
                    rsp_data_nx = '0;
                    state_nx    = HOLD;
                end else begin
                    wait_nx = wait_cnt + 1'b1;
                end
            end
            HOLD: begin
                if (host_rsp_ready) begin
                    valid_nx    = 1'b0;
                    code_nx     = '0;
                    rsp_data_nx = '0;
                    state_nx    = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_calc1_port_driver.sv
// Directed bench for calc1_port_driver with a small behavioural calc1 responder
// that can be switched off to act as a never-responding stub.
module tb_calc1_port_driver;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic        c_clk = 1'b0;
    logic        reset;
    logic        host_req_valid;
    logic        host_req_ready;
    logic [0:3]  host_req_cmd;
    logic [0:31] host_req_op1;
    logic [0:31] host_req_op2;
    logic        host_rsp_valid;
    logic        host_rsp_ready;
    logic [0:1]  host_rsp_code;
    logic [0:31] host_rsp_data;
    logic [0:3]  req_cmd_in;
    logic [0:31] req_data_in;
    logic [0:1]  out_resp = '0;
    logic [0:31] out_data = '0;
    logic [2:0]  fifo_count;
    logic        spurious_resp;

    int checks   = 0;
    int failures = 0;

    bit model_en  = 1'b1;
    int rsp_delay = 1;
    int phase     = 0;
    int cnt       = 0;
    logic [0:3]  m_cmd;
    logic [0:31] m_op1, m_op2, m_res;
    logic [0:1]  m_code;
    logic [32:0] wide;

    calc1_port_driver #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .c_clk(c_clk), .reset(reset),
        .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
        .host_req_cmd(host_req_cmd), .host_req_op1(host_req_op1), .host_req_op2(host_req_op2),
        .host_rsp_valid(host_rsp_valid), .host_rsp_ready(host_rsp_ready),
        .host_rsp_code(host_rsp_code), .host_rsp_data(host_rsp_data),
        .req_cmd_in(req_cmd_in), .req_data_in(req_data_in),
        .out_resp(out_resp), .out_data(out_data),
        .fifo_count(fifo_count), .spurious_resp(spurious_resp)
    );

    always #5 c_clk = ~c_clk;

    // calc1 stand-in: samples the request bus on falling edges, answers rsp_delay cycles after op2.
    always @(negedge c_clk) begin
        out_resp = 2'd0;
        out_data = '0;
        if (!model_en) begin
            phase = 0;
        end else begin
            case (phase)
                0: if (req_cmd_in != 4'd0) begin
                    m_cmd = req_cmd_in;
                    m_op1 = req_data_in;
                    phase = 1;
                end
                1: begin
                    m_op2 = req_data_in;
                    case (m_cmd)
                        4'd1: begin
                            wide = {1'b0, m_op1} + {1'b0, m_op2};
                            if (wide[32]) begin m_code = 2'd2; m_res = '0; end
                            else begin m_code = 2'd1; m_res = wide[31:0]; end
                        end
                        4'd2: begin
                            if (m_op2 > m_op1) begin m_code = 2'd2; m_res = '0; end
                            else begin m_code = 2'd1; m_res = m_op1 - m_op2; end
                        end
                        4'd5: begin m_code = 2'd1; m_res = m_op1 << m_op2[27:31]; end
                        4'd6: begin m_code = 2'd1; m_res = m_op1 >> m_op2[27:31]; end
                        default: begin m_code = 2'd2; m_res = '0; end
                    endcase
                    cnt   = rsp_delay;
                    phase = 2;
                end
                2: if (cnt == 0) begin
                    out_resp = m_code;
                    out_data = m_res;
                    phase    = 0;
                end else begin
                    cnt = cnt - 1;
                end
                default: phase = 0;
            endcase
        end
    end

    task automatic tick;
        @(posedge c_clk);
        #1;
    endtask

    task automatic push(input logic [0:3] cmd, input logic [0:31] a, input logic [0:31] b);
        host_req_valid = 1'b1;
        host_req_cmd   = cmd;
        host_req_op1   = a;
        host_req_op2   = b;
        tick();
        host_req_valid = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i <= limit; i++) begin
            if (host_rsp_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic accept;
        host_rsp_ready = 1'b1;
        tick();
        host_rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        host_req_valid = 1'b0; host_req_cmd = '0; host_req_op1 = '0; host_req_op2 = '0;
        host_rsp_ready = 1'b0;
        tick(); tick();
        checks++;
        if ({host_rsp_valid, host_rsp_code, host_rsp_data, req_cmd_in, req_data_in,
             fifo_count, spurious_resp} !== 75'd0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b code=%0d data=%h cmd=%0d bus=%h count=%0d spur=%b, all must be 0",
                     host_rsp_valid, host_rsp_code, host_rsp_data, req_cmd_in, req_data_in,
                     fifo_count, spurious_resp);
        end
        checks++;
        if (host_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b expected 1", host_req_ready);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_add_basic;
        bit ok;
        push(4'd1, 32'h0000_0001, 32'h01FF_FFFF);
        checks++;
        if (fifo_count !== 3'd1) begin
            failures++; $display("FAIL add_count_after_push: got %0d expected 1", fifo_count);
        end
        tick();
        checks++;
        if (req_cmd_in !== 4'd1 || req_data_in !== 32'h0000_0001) begin
            failures++;
            $display("FAIL add_op1_bus: got cmd=%0d data=%h expected cmd=1 data=00000001", req_cmd_in, req_data_in);
        end
        tick();
        checks++;
        if (req_cmd_in !== 4'd0 || req_data_in !== 32'h01FF_FFFF) begin
            failures++;
            $display("FAIL add_op2_bus: got cmd=%0d data=%h expected cmd=0 data=01ffffff", req_cmd_in, req_data_in);
        end
        tick();
        checks++;
        if (req_cmd_in !== 4'd0 || req_data_in !== 32'h0) begin
            failures++;
            $display("FAIL add_wait_bus: got cmd=%0d data=%h expected 0/0", req_cmd_in, req_data_in);
        end
        wait_valid(40, ok);
        checks++;
        if (!ok || host_rsp_code !== 2'd1 || host_rsp_data !== 32'h0200_0000) begin
            failures++;
            $display("FAIL add_result: valid=%b code=%0d data=%h expected valid=1 code=1 data=02000000",
                     ok, host_rsp_code, host_rsp_data);
        end
        accept();
        checks++;
        if (host_rsp_valid !== 1'b0) begin
            failures++; $display("FAIL add_valid_drop: got %b expected 0", host_rsp_valid);
        end
    endtask

    task automatic test_overflow;
        bit ok;
        push(4'd1, 32'hFFFF_FFFF, 32'h0000_0001);
        wait_valid(40, ok);
        checks++;
        if (!ok || host_rsp_code !== 2'd2 || host_rsp_data !== 32'h0) begin
            failures++;
            $display("FAIL overflow_result: valid=%b code=%0d data=%h expected valid=1 code=2 data=0",
                     ok, host_rsp_code, host_rsp_data);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (host_rsp_valid !== 1'b1 || host_rsp_code !== 2'd2) begin
                failures++;
                $display("FAIL overflow_hold: cycle %0d valid=%b code=%0d expected valid=1 code=2",
                         k, host_rsp_valid, host_rsp_code);
            end
        end
        accept();
    endtask

    task automatic test_invalid;
        bit ok;
        push(4'd3, 32'h0000_0001, 32'h0000_0002);
        wait_valid(40, ok);
        checks++;
        if (!ok || host_rsp_code !== 2'd2) begin
            failures++; $display("FAIL invalid_cmd3: valid=%b code=%0d expected valid=1 code=2", ok, host_rsp_code);
        end
        accept();
        push(4'd4, 32'h0000_0009, 32'h0000_0003);
        wait_valid(40, ok);
        checks++;
        if (!ok || host_rsp_code !== 2'd2) begin
            failures++; $display("FAIL invalid_cmd4: valid=%b code=%0d expected valid=1 code=2", ok, host_rsp_code);
        end
        accept();
    endtask

    task automatic test_back_to_back;
        bit ok;
        logic [0:31] exp_data [5];
        int extra;
        exp_data[0] = 32'h0000_0101; exp_data[1] = 32'h0000_0202; exp_data[2] = 32'h0000_0303;
        exp_data[3] = 32'h0000_0404; exp_data[4] = 32'h0000_0505;
        host_rsp_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            host_req_valid = 1'b1;
            host_req_cmd   = 4'd1;
            host_req_op1   = 32'h100 * (k + 1);
            host_req_op2   = k + 1;
            checks++;
            if (host_req_ready !== ((k < 5) ? 1'b1 : 1'b0)) begin
                failures++;
                $display("FAIL b2b_ready: push %0d ready=%b expected %b", k, host_req_ready, (k < 5));
            end
            tick();
        end
        host_req_valid = 1'b0;
        checks++;
        if (fifo_count !== 3'd4) begin
            failures++; $display("FAIL b2b_count_full: got %0d expected 4", fifo_count);
        end
        wait_valid(40, ok);
        host_rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_valid(60, ok);
            checks++;
            if (!ok || host_rsp_code !== 2'd1 || host_rsp_data !== exp_data[i]) begin
                failures++;
                $display("FAIL b2b_result: #%0d valid=%b code=%0d data=%h expected code=1 data=%h",
                         i, ok, host_rsp_code, host_rsp_data, exp_data[i]);
            end
            tick();
        end
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            if (host_rsp_valid) extra++;
            tick();
        end
        host_rsp_ready = 1'b0;
        checks++;
        if (extra !== 0 || fifo_count !== 3'd0) begin
            failures++;
            $display("FAIL b2b_drained: extra valid cycles=%0d count=%0d expected 0/0", extra, fifo_count);
        end
    endtask

    task automatic test_timeout;
        int c;
        bit ok;
        model_en = 1'b0;
        push(4'd1, 32'h0000_0005, 32'h0000_0006);
        tick(); tick(); tick();
        // Now just past the op2 edge; valid first rises after the TIMEOUT-th edge from here.
        c = 0;
        while (!host_rsp_valid && c < 3 * TIMEOUT) begin
            tick();
            c++;
        end
        checks++;
        if (c !== TIMEOUT) begin
            failures++; $display("FAIL timeout_latency: valid after %0d edges expected %0d", c, TIMEOUT);
        end
        checks++;
        if (host_rsp_valid !== 1'b1 || host_rsp_code !== 2'd3 || host_rsp_data !== 32'h0) begin
            failures++;
            $display("FAIL timeout_result: valid=%b code=%0d data=%h expected 1/3/0",
                     host_rsp_valid, host_rsp_code, host_rsp_data);
        end
        accept();
        model_en = 1'b1;
        push(4'd0, 32'h0000_0007, 32'h0000_0008);
        wait_valid(3 * TIMEOUT, ok);
        checks++;
        if (!ok || host_rsp_code !== 2'd3 || host_rsp_data !== 32'h0) begin
            failures++;
            $display("FAIL nop_timeout: valid=%b code=%0d data=%h expected 1/3/0", ok, host_rsp_code, host_rsp_data);
        end
        accept();
    endtask

    task automatic test_reset_mid;
        int sp_cycles;
        int v_cycles;
        rsp_delay = 6;
        push(4'd1, 32'h0000_0002, 32'h0000_0003);
        tick(); tick(); tick(); tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({host_rsp_valid, host_rsp_code, host_rsp_data, req_cmd_in, req_data_in,
             fifo_count, spurious_resp} !== 75'd0 || host_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_outputs: valid=%b code=%0d data=%h cmd=%0d bus=%h count=%0d spur=%b ready=%b expected zeros, ready=1",
                     host_rsp_valid, host_rsp_code, host_rsp_data, req_cmd_in, req_data_in,
                     fifo_count, spurious_resp, host_req_ready);
        end
        reset = 1'b0;
        sp_cycles = 0;
        v_cycles  = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (spurious_resp) sp_cycles++;
            if (host_rsp_valid) v_cycles++;
        end
        checks++;
        if (sp_cycles !== 1) begin
            failures++; $display("FAIL midreset_spurious: pulse cycles=%0d expected 1", sp_cycles);
        end
        checks++;
        if (v_cycles !== 0) begin
            failures++; $display("FAIL midreset_no_rsp: valid cycles=%0d expected 0", v_cycles);
        end
        rsp_delay = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_add_basic();
        test_overflow();
        test_invalid();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
